// File: rtl/ex_alu_seq.sv
// ex_alu_seq: three-state sequencer that decodes an ALU request, drives an external ALU and holds the result until accepted (optional signed branches via EX_ALU_SIGNED_BR_EN)
module ex_alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic [4:0]  in_rd,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_taken,
  output logic        out_illegal
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [63:0] a_q, b_q;
  logic [3:0] op_q;
  logic [4:0] rd_q;
  logic [1:0] cls_q;
  logic [2:0] f3_q;
  logic ill_q;
  logic [3:0] dec_op;
  logic dec_ill;
  logic taken;
  assign in_ready = state == IDLE;
  assign out_valid = state == HOLD;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  // decode the incoming request into an ALU opcode and an illegal flag
  always_comb begin
    dec_op = 4'b0010;
    dec_ill = 1'b0;
    case (in_class)
      2'b00: dec_op = 4'b0010;
      2'b10:
        case (in_funct3)
          3'b000: dec_op = in_funct7_5 ? 4'b0110 : 4'b0010;
          3'b111: dec_op = 4'b0000;
          3'b110: dec_op = 4'b0001;
          3'b001: dec_op = 4'b1111;
          default: dec_ill = 1'b1;
        endcase
      2'b01: begin
        dec_op = 4'b0110;
        case (in_funct3)
          3'b000, 3'b001, 3'b110, 3'b111: dec_ill = 1'b0;
`ifdef EX_ALU_SIGNED_BR_EN
          3'b100, 3'b101: dec_ill = 1'b0;
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end
`ifdef EX_ALU_SIGNED_BR_EN
  logic slt;
  assign slt = $signed(a_q) < $signed(b_q);
`endif
  // branch decision from the registered request and the ALU flags
  always_comb begin
    taken = 1'b0;
    if (cls_q == 2'b01 && !ill_q)
      case (f3_q)
        3'b000: taken = alu_zero;
        3'b001: taken = ~alu_zero;
        3'b110: taken = alu_lt;
        3'b111: taken = ~alu_lt;
`ifdef EX_ALU_SIGNED_BR_EN
        3'b100: taken = slt;
        3'b101: taken = ~slt;
`endif
        default: taken = 1'b0;
      endcase
  end
  // sequencer: accept in IDLE, capture in EXEC, hold until downstream takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      rd_q <= '0;
      cls_q <= '0;
      f3_q <= '0;
      ill_q <= 1'b0;
      out_result <= '0;
      out_rd <= '0;
      out_taken <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            a_q <= in_a;
            b_q <= (in_class == 2'b10 && in_funct3 == 3'b001 && !dec_ill) ? {58'b0, in_b[5:0]} : in_b;
            op_q <= dec_ill ? 4'b0010 : dec_op;
            rd_q <= in_rd;
            cls_q <= in_class;
            f3_q <= in_funct3;
            ill_q <= dec_ill;
            state <= EXEC;
          end
        EXEC: begin
          out_result <= ill_q ? 64'd0 : alu_result;
          out_rd <= rd_q;
          out_taken <= taken;
          out_illegal <= ill_q;
          state <= HOLD;
        end
        HOLD: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_alu_seq.sv
// tb_ex_alu_seq: directed vector table plus hand sequences for back-pressure, ignored requests and reset
module tb_ex_alu_seq;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_funct7_5 = 1'b0;
  logic [1:0] in_class = '0;
  logic [2:0] in_funct3 = '0;
  logic [63:0] in_a = '0, in_b = '0;
  logic [4:0] in_rd = '0;
  logic [63:0] alu_a, alu_b, alu_result, out_result;
  logic [3:0] alu_op;
  logic alu_zero, alu_lt, out_valid, out_ready = 1'b0, out_taken, out_illegal;
  logic [4:0] out_rd;
  int checks = 0, errors = 0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef struct {
    logic [1:0] c; logic [2:0] f3; logic f7; logic [63:0] a, b; logic [4:0] rd;
    logic [3:0] op; logic [63:0] alub, res; logic tk, il;
  } vec_t;
  vec_t v[15];

  ex_alu_seq dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_a(in_a),
    .in_b(in_b), .in_rd(in_rd), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_taken(out_taken),
    .out_illegal(out_illegal));

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1111: alu_result = alu_a << alu_b[5:0];
      default: alu_result = '0;
    endcase
    alu_zero = alu_result == 64'd0;
    alu_lt = alu_a < alu_b;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [2:0] f3, input logic f7,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    in_class = c; in_funct3 = f3; in_funct7_5 = f7; in_a = a; in_b = b; in_rd = rd;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("back_idle", {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    v[0]  = '{2'b10, 3'b000, 1'b0, 64'd5, 64'd7, 5'd1, 4'b0010, 64'd7, 64'd12, 1'b0, 1'b0};
    v[1]  = '{2'b10, 3'b000, 1'b1, 64'd5, 64'd7, 5'd2, 4'b0110, 64'd7, ONES - 64'd1, 1'b0, 1'b0};
    v[2]  = '{2'b10, 3'b111, 1'b0, 64'hF0F0, 64'hFF00, 5'd3, 4'b0000, 64'hFF00, 64'hF000, 1'b0, 1'b0};
    v[3]  = '{2'b10, 3'b110, 1'b0, 64'hF0, 64'h0F, 5'd4, 4'b0001, 64'h0F, 64'hFF, 1'b0, 1'b0};
    v[4]  = '{2'b10, 3'b001, 1'b0, 64'd3, 64'h41, 5'd5, 4'b1111, 64'd1, 64'd6, 1'b0, 1'b0};
    v[5]  = '{2'b00, 3'b011, 1'b0, 64'd100, 64'd28, 5'd6, 4'b0010, 64'd28, 64'd128, 1'b0, 1'b0};
    v[6]  = '{2'b01, 3'b000, 1'b0, 64'd9, 64'd9, 5'd7, 4'b0110, 64'd9, 64'd0, 1'b1, 1'b0};
    v[7]  = '{2'b01, 3'b001, 1'b0, 64'd9, 64'd9, 5'd8, 4'b0110, 64'd9, 64'd0, 1'b0, 1'b0};
    v[8]  = '{2'b01, 3'b110, 1'b0, 64'd1, ONES, 5'd9, 4'b0110, ONES, 64'd2, 1'b1, 1'b0};
    v[9]  = '{2'b01, 3'b111, 1'b0, 64'd1, ONES, 5'd10, 4'b0110, ONES, 64'd2, 1'b0, 1'b0};
    v[10] = '{2'b11, 3'b000, 1'b0, 64'd5, 64'd7, 5'd11, 4'b0010, 64'd7, 64'd0, 1'b0, 1'b1};
    v[11] = '{2'b10, 3'b010, 1'b0, 64'd5, 64'd7, 5'd12, 4'b0010, 64'd7, 64'd0, 1'b0, 1'b1};
    v[12] = '{2'b01, 3'b000, 1'b0, 64'd3, 64'd4, 5'd13, 4'b0110, 64'd4, ONES, 1'b0, 1'b0};
`ifdef EX_ALU_SIGNED_BR_EN
    v[13] = '{2'b01, 3'b100, 1'b0, ONES, 64'd0, 5'd14, 4'b0110, 64'd0, ONES, 1'b1, 1'b0};
    v[14] = '{2'b01, 3'b101, 1'b0, ONES, 64'd0, 5'd15, 4'b0110, 64'd0, ONES, 1'b0, 1'b0};
`else
    v[13] = '{2'b01, 3'b100, 1'b0, ONES, 64'd0, 5'd14, 4'b0010, 64'd0, 64'd0, 1'b0, 1'b1};
    v[14] = '{2'b01, 3'b101, 1'b0, ONES, 64'd0, 5'd15, 4'b0010, 64'd0, 64'd0, 1'b0, 1'b1};
`endif
    #2;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_alu_op", {60'b0, alu_op}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      issue(v[i].c, v[i].f3, v[i].f7, v[i].a, v[i].b, v[i].rd);
      chk($sformatf("v%0d_exec_valid", i), {63'b0, out_valid}, 64'd0);
      chk($sformatf("v%0d_alu_op", i), {60'b0, alu_op}, {60'b0, v[i].op});
      chk($sformatf("v%0d_alu_b", i), alu_b, v[i].alub);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), {63'b0, out_valid}, 64'd1);
      chk($sformatf("v%0d_result", i), out_result, v[i].res);
      chk($sformatf("v%0d_taken", i), {63'b0, out_taken}, {63'b0, v[i].tk});
      chk($sformatf("v%0d_illegal", i), {63'b0, out_illegal}, {63'b0, v[i].il});
      chk($sformatf("v%0d_rd", i), {59'b0, out_rd}, {59'b0, v[i].rd});
      release_out();
    end
    issue(2'b10, 3'b000, 1'b1, 64'd5, 64'd7, 5'd20);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_result", out_result, ONES - 64'd1);
      @(posedge clk); #1;
    end
    release_out();
    chk("bp_valid_drop", {63'b0, out_valid}, 64'd0);
    issue(2'b10, 3'b000, 1'b0, 64'd5, 64'd7, 5'd3);
    @(posedge clk); #1;
    in_class = 2'b10; in_funct3 = 3'b000; in_funct7_5 = 1'b1; in_a = 64'd100; in_b = 64'd1; in_rd = 5'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("ign_in_ready", {63'b0, in_ready}, 64'd0);
      chk("ign_result", out_result, 64'd12);
      chk("ign_rd", {59'b0, out_rd}, 64'd3);
      chk("ign_alu_a", alu_a, 64'd5);
      @(posedge clk); #1;
    end
    release_out();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ign_next_alu_a", alu_a, 64'd100);
    @(posedge clk); #1;
    chk("ign_next_result", out_result, 64'd99);
    chk("ign_next_rd", {59'b0, out_rd}, 64'd9);
    release_out();
    issue(2'b00, 3'b000, 1'b0, 64'd1, 64'd2, 5'd4);
    #1 reset = 1'b1;
    #1;
    chk("rx_valid", {63'b0, out_valid}, 64'd0);
    chk("rx_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rx_alu_op", {60'b0, alu_op}, 64'd0);
    @(posedge clk); #1;
    chk("rx_in_ready_hold", {63'b0, in_ready}, 64'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rx_no_valid", {63'b0, out_valid}, 64'd0);
    end
    issue(2'b00, 3'b000, 1'b0, 64'd1, 64'd2, 5'd4);
    @(posedge clk); #1;
    chk("rx_after_valid", {63'b0, out_valid}, 64'd1);
    chk("rx_after_result", out_result, 64'd3);
    release_out();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_alu_seq.md
EX_ALU_SEQ -- requirements
Module: ex_alu_seq

Interface
REQ-001 The block SHALL have a single clock, clk: input, 1 bit, rising-edge.
REQ-002 The block SHALL have a reset, reset: input, 1 bit; it is asynchronous and active-high.
REQ-003 The block SHALL have these request-side ports:
- in_valid input 1: request present.
- in_ready output 1: block can accept a request.
- in_class input 2: main-control ALU class; 00 = load/store, 01 = branch, 10 = R-type, 11 = reserved.
- in_funct3 input 3: instruction funct3.
- in_funct7_5 input 1: instruction bit 30.
- in_a input 64: operand A.
- in_b input 64: operand B.
- in_rd input 5: destination register tag.
REQ-004 The block SHALL have these ALU-side ports:
- alu_a output 64: operand A to the ALU.
- alu_b output 64: operand B to the ALU.
- alu_op output 4: ALU opcode.
- alu_result input 64: ALU result.
- alu_zero input 1: ALU zero flag.
- alu_lt input 1: ALU unsigned a<b flag.
REQ-005 The block SHALL have these result-side ports:
- out_valid output 1: result present.
- out_ready input 1: downstream accepts the result.
- out_result output 64: captured result.
- out_rd output 5: captured destination tag.
- out_taken output 1: branch decision.
- out_illegal output 1: unsupported encoding.

Function
REQ-006 The FSM SHALL have the states IDLE, EXEC and HOLD; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD.
REQ-007 In IDLE, when in_valid=1, the block SHALL register the operands, in_rd and the decoded opcode, then move to EXEC; otherwise it SHALL stay in IDLE.
REQ-008 In EXEC, alu_a, alu_b and alu_op SHALL be driven from the registered values. At the EXEC clock edge the block SHALL capture alu_result, the branch decision and the illegal flag into the out_* registers, then move to HOLD.
REQ-009 In HOLD, all out_* signals SHALL be stable until out_ready=1. On that handshake the block SHALL return to IDLE; there is no new accept in that same cycle.
REQ-010 The minimum accept-to-result latency SHALL be 2 cycles, and the throughput SHALL be 1 operation per 3 cycles.
REQ-011 alu_a, alu_b and alu_op SHALL hold their last values outside EXEC.
REQ-012 Decode, class 00: alu_op SHALL be 0010 (ADD).
REQ-013 Decode, class 10:
- funct3 000 with funct7_5=0: 0010 (ADD).
- funct3 000 with funct7_5=1: 0110 (SUB).
- funct3 111: 0000 (AND).
- funct3 110: 0001 (OR).
- funct3 001: 1111 (SLL), with alu_b = {58'b0, in_b[5:0]}.
REQ-014 Decode, class 01: alu_op SHALL be 0110 (SUB), with out_taken as follows:
- funct3 000 (beq): alu_zero.
- funct3 001 (bne): ~alu_zero.
- funct3 110 (bltu): alu_lt.
- funct3 111 (bgeu): ~alu_lt.
REQ-015 For any class other than 01, out_taken SHALL be 0.
REQ-016 Any unlisted encoding, and class 11, SHALL be illegal:
- alu_op = 0010.
- out_result = 0.
- out_taken = 0.
- out_illegal = 1.
- The transaction still completes through HOLD.
REQ-017 in_valid asserted while the block is not in IDLE SHALL be ignored, and the input registers SHALL NOT change.

Reset
REQ-018 When reset is asserted, the block SHALL immediately force the state to IDLE and all outputs to 0. It SHALL then drive in_ready=1 from IDLE while reset stays high.
REQ-019 A reset asserted during EXEC or HOLD SHALL discard the transaction, and no out_valid pulse SHALL follow.

Configuration
REQ-020 With the macro EX_ALU_SIGNED_BR_EN defined, class 01 SHALL add two signed branches, computed from an internal signed comparison of the registered operands:
- funct3 100 (blt): out_taken = signed(a)<signed(b).
- funct3 101 (bge): out_taken = its inverse.
REQ-021 Without EX_ALU_SIGNED_BR_EN, funct3 100 and 101 in class 01 SHALL be illegal per REQ-016.

Verification
REQ-022 R-type ADD, and R-type SUB under back-pressure:
- class=10, f3=000, f7_5=0, a=5, b=7 -> out_result=12 and out_valid two cycles after accept.
- f7_5=1 with out_ready held low for 4 cycles -> out_result=0xFFFFFFFFFFFFFFFE held stable for those cycles.
REQ-023 SLL: class=10, f3=001, b=0x41 -> alu_b=1 and alu_op=1111; with a=3 -> out_result=6.
REQ-024 Unsigned branches:
- beq with a=b=9 -> out_taken=1.
- bltu with a=1, b=0xFFFFFFFFFFFFFFFF -> out_taken=1.
- bgeu with the same operands -> out_taken=0.
REQ-025 Illegal encodings:
- class=11 -> out_illegal=1 and out_result=0.
- class=01, f3=100 -> illegal without EX_ALU_SIGNED_BR_EN.
- class=01, f3=100, a=-1, b=0 -> out_taken=1 with EX_ALU_SIGNED_BR_EN.
REQ-026 Reset and ignored requests:
- Reset asserted in EXEC -> out_valid stays 0; the next accept completes normally.
- in_valid held high during HOLD -> no second capture until the block returns to IDLE.
